// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the IF stage.
// A program arrives as a byte stream: a 16-bit big-endian word count, then the words, each
// sent MSB first. Fetches are served only after a load completes. Each fetch returns a
// registered result one cycle later. Fetch can be stalled.
module instr_mem_loadable #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  input  logic              fetch_en,
  input  logic              fetch_stall,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid
);

  localparam int unsigned BPW = DATA_W / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A   = (ADDR_W + 1)'(DEPTH);
  localparam logic [16:0]      DEPTH_L   = 17'(DEPTH);
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(BPW - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       remain_q, remain_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] word_buf_q, word_buf_d;
  logic              load_err_q, load_err_d;
  logic              load_done_q, load_done_d;
  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;

  logic              accept;
  logic              we;
  logic [DATA_W-1:0] word_next;
  logic [15:0]       len_word;
  logic              pc_in_range;

  // Not reset: contents survive reset and partial loads.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  assign load_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign accept      = load_valid && load_ready;
  // Shift the new byte in at the LSB end so the first byte of a word ends up as the MSBs.
  assign word_next   = DATA_W'({word_buf_q, load_byte});
  assign len_word    = {len_hi_q, load_byte};
  assign pc_in_range = {1'b0, pc} < DEPTH_A;

  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

  // Load FSM next-state: parse length, assemble words, decide write and completion.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    remain_d    = remain_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_buf_d  = word_buf_q;
    load_err_d  = load_err_q;
    load_done_d = 1'b0;
    we          = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (load_start) begin
          state_d    = S_LEN_HI;
          load_err_d = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = load_byte;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          word_cnt_d = '0;
          byte_cnt_d = '0;
          remain_d   = len_word;
          if (len_word == 16'd0) begin
            state_d     = S_RUN;
            load_done_d = 1'b1;
          end else begin
            state_d    = S_DATA;
            load_err_d = {1'b0, len_word} > DEPTH_L;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_buf_d = word_next;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            // Words beyond DEPTH are consumed but dropped; the index saturates so it never wraps.
            if (word_cnt_q < DEPTH_A) begin
              we         = 1'b1;
              word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
            end
            remain_d = remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              state_d     = S_RUN;
              load_done_d = 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load FSM state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_hi_q    <= '0;
      remain_q    <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      word_buf_q  <= '0;
      load_err_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      remain_q    <= remain_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_buf_q  <= word_buf_d;
      load_err_q  <= load_err_d;
      load_done_q <= load_done_d;
    end
  end

  // Memory write port, one word per completed word of the stream.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[word_cnt_q[MAW-1:0]] <= word_next;
    end
  end

  // Registered fetch port; a new load start takes priority over stall and fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
    end else if (state_q != S_RUN || load_start) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
    end else if (fetch_stall) begin
      instr_q       <= instr_q;
      instr_valid_q <= instr_valid_q;
    end else if (fetch_en) begin
      instr_q       <= pc_in_range ? mem[pc[MAW-1:0]] : NOP_WORD;
      instr_valid_q <= 1'b1;
    end else begin
      instr_valid_q <= 1'b0;
    end
  end

endmodule
